inv_mixcol_seq: RTL
===================

INV_MIXCOL_SEQ -- requirements
Module: inv_mixcol_seq

Interface
REQ-001 SHALL have parameter NUM_COLS, default 4, meaning number of 32-bit columns per 128-bit state; only the value 4 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  source presents a state on in_data.
REQ-005 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-006 SHALL have port in_data  input  128  AES state; column c occupies bits [127-32c -: 32], byte a0 in the column MSB.
REQ-007 SHALL have port abort  input  1  synchronous cancel of any operation in progress.
REQ-008 SHALL have port out_valid  output  1  out_data holds a completed result.
REQ-009 SHALL have port out_ready  input  1  sink accepts out_data.
REQ-010 SHALL have port out_data  output  128  transformed state, same byte layout as in_data.
REQ-011 SHALL have port busy  output  1  high in the BUSY state.

Function
REQ-012 SHALL implement an FSM with the states IDLE, BUSY and DONE; in_ready = (state==IDLE) and out_valid = (state==DONE), both registered-state decodes.
REQ-013 SHALL, in IDLE when in_valid&in_ready, capture in_data into the work register, clear col_cnt to 0 and enter BUSY.
REQ-014 SHALL, in BUSY, replace column col_cnt of the work register with its InvMixColumns result each cycle: b0=14a0^11a1^13a2^9a3, b1=9a0^14a1^11a2^13a3, b2=13a0^9a1^14a2^11a3, b3=11a0^13a1^9a2^14a3, all in GF(2^8) mod 0x11B.
REQ-015 SHALL increment col_cnt (2 bits) per BUSY cycle and enter DONE on the edge that writes column 3; col_cnt wraps to 0.
REQ-016 SHALL give a fixed latency of exactly 4 clocks from the accept edge to out_valid high.
REQ-017 SHALL hold out_data and out_valid stable in DONE until out_valid&out_ready, then return to IDLE; no input is accepted in the same cycle (in_ready is 0 in DONE).
REQ-018 SHALL drive out_data from the work register at all times; its value is only meaningful while out_valid=1.
REQ-019 SHALL, when abort=1, go to IDLE on the next edge from any state and discard the work register contents; abort has priority over an accept and over an output handshake in the same cycle.
REQ-020 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.

Reset
REQ-021 SHALL, on rst_n low, asynchronously force state=IDLE, col_cnt=0, work register=0 and mode=0, giving in_ready=1, out_valid=0, busy=0 and out_data=0.
REQ-022 SHALL, when reset is asserted mid-operation, drop the operation; after release the first accept starts a fresh 4-cycle operation.

Configuration
REQ-023 SHALL, when INV_MIXCOL_FWD_EN is defined, add the input port fwd (1 bit), capture it at accept, and apply forward MixColumns (b0=2a0^3a1^a2^a3, rotated for b1..b3) when the captured value is 1.
REQ-024 SHALL, when INV_MIXCOL_FWD_EN is undefined, omit the fwd port and perform InvMixColumns only, with identical timing.

Structure
REQ-025 SHALL take the state width (128), column width (32), NUM_COLS and the FSM state enum from the shared package aes_pkg.
REQ-026 SHALL place the one-column transform in the combinational sub-module inv_mixcol_col (32-bit in, 32-bit out, plus the fwd select under the macro), built from xtime-based GF multiplies rather than 256-entry tables.

Verification
REQ-027 SHALL cover: all four columns 8e4da1bc -> out_data 4 clocks after accept, every column db135345.
REQ-028 SHALL cover: columns 9fdc589d, 01010101, d5d5d7d6, 4d7ebdf8 -> out_data f20a225c_01010101_d4d4d4d5_2d26314c.
REQ-029 SHALL cover: out_ready held low for 10 cycles after DONE -> out_valid and out_data stable, in_ready=0 throughout; a new in_valid during this time is not accepted.
REQ-030 SHALL cover: abort pulsed at col_cnt=2 -> IDLE on the next edge, in_ready=1, out_valid never asserted; the next accepted state completes correctly.
REQ-031 SHALL cover: rst_n pulled low in BUSY -> outputs are immediately in_ready=1, out_valid=0, out_data=0.
REQ-032 SHALL cover, with INV_MIXCOL_FWD_EN defined: fwd=1, all columns db135345 -> out_data all columns 8e4da1bc.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: state/column geometry, FSM state encoding and the
// GF(2^8) xtime primitive used by the column transforms.
package aes_pkg;

    localparam int AES_STATE_W  = 128;
    localparam int AES_COL_W    = 32;
    localparam int AES_NUM_COLS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } aes_state_e;

    // Multiply by x (0x02) in GF(2^8), reduced modulo x^8+x^4+x^3+x+1 (0x11B).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mixcol_col.sv
// One-column (Inv)MixColumns, purely combinational.
// Every constant multiply is built from chained xtime (x2, x4, x8) terms:
//   9 = 8^1, 11 = 8^2^1, 13 = 8^4^1, 14 = 8^4^2.
// Optional build macro INV_MIXCOL_FWD_EN adds fwd_i, selecting forward
// MixColumns when high.
module inv_mixcol_col
    import aes_pkg::*;
(
`ifdef INV_MIXCOL_FWD_EN
    input  logic                 fwd_i,
`endif
    input  logic [AES_COL_W-1:0] col_i,
    output logic [AES_COL_W-1:0] col_o
);

    logic [7:0] a   [4];
    logic [7:0] x2  [4];
    logic [7:0] x4  [4];
    logic [7:0] x8  [4];
    logic [7:0] m9  [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] inv_b [4];

    // Byte i is a_i; a0 sits in the column MSB.
    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign a[i]   = col_i[AES_COL_W-1-8*i -: 8];
        assign x2[i]  = xtime(a[i]);
        assign x4[i]  = xtime(x2[i]);
        assign x8[i]  = xtime(x4[i]);
        assign m9[i]  = x8[i] ^ a[i];
        assign m11[i] = x8[i] ^ x2[i] ^ a[i];
        assign m13[i] = x8[i] ^ x4[i] ^ a[i];
        assign m14[i] = x8[i] ^ x4[i] ^ x2[i];

        // b_i = 14 a_i ^ 11 a_(i+1) ^ 13 a_(i+2) ^ 9 a_(i+3), indices mod 4.
        assign inv_b[i] = m14[i] ^ m11[(i+1)%4] ^ m13[(i+2)%4] ^ m9[(i+3)%4];

`ifdef INV_MIXCOL_FWD_EN
        // b_i = 2 a_i ^ 3 a_(i+1) ^ a_(i+2) ^ a_(i+3), indices mod 4.
        logic [7:0] fwd_b;
        assign fwd_b = x2[i] ^ (x2[(i+1)%4] ^ a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
        assign col_o[AES_COL_W-1-8*i -: 8] = fwd_i ? fwd_b : inv_b[i];
`else
        assign col_o[AES_COL_W-1-8*i -: 8] = inv_b[i];
`endif
    end

endmodule

// File: rtl/inv_mixcol_seq.sv
// Sequential InvMixColumns over a 128-bit AES state, one column per clock.
// Accept in IDLE, four BUSY cycles (columns 0..3), then hold the result in
// DONE until the sink takes it. abort returns to IDLE from any state.
// Optional build macro INV_MIXCOL_FWD_EN adds the fwd input; the value sampled
// at accept selects forward MixColumns for that operation.
module inv_mixcol_seq
    import aes_pkg::*;
#(
    parameter int NUM_COLS = AES_NUM_COLS  // only 4 is supported
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
`ifdef INV_MIXCOL_FWD_EN
    input  logic                   fwd,
`endif
    input  logic                   abort,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data,
    output logic                   busy
);

    typedef logic [NUM_COLS-1:0][AES_COL_W-1:0] work_t;

    aes_state_e     state_q, state_d;
    logic [1:0]     col_cnt_q, col_cnt_d;
    work_t          work_q, work_d;
    logic [1:0]     col_idx;
    logic [AES_COL_W-1:0] col_in, col_out;
`ifdef INV_MIXCOL_FWD_EN
    logic           mode_q, mode_d;
`endif

    // Column c lives in the packed slot NUM_COLS-1-c, which for a 2-bit
    // counter is simply its bitwise complement.
    assign col_idx = ~col_cnt_q;
    assign col_in  = work_q[col_idx];

    inv_mixcol_col u_col (
`ifdef INV_MIXCOL_FWD_EN
        .fwd_i (mode_q),
`endif
        .col_i (col_in),
        .col_o (col_out)
    );

    // Registered-state decodes, so the handshake outputs are glitch-free.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY);
    assign out_data  = work_q;

    // Next-state and datapath update; abort outranks accept and handshake.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        work_d    = work_q;
`ifdef INV_MIXCOL_FWD_EN
        mode_d    = mode_q;
`endif
        if (abort) begin
            state_d   = ST_IDLE;
            col_cnt_d = 2'd0;
            work_d    = '0;
`ifdef INV_MIXCOL_FWD_EN
            mode_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_d    = in_data;
                        col_cnt_d = 2'd0;
                        state_d   = ST_BUSY;
`ifdef INV_MIXCOL_FWD_EN
                        mode_d    = fwd;
`endif
                    end
                end
                ST_BUSY: begin
                    work_d[col_idx] = col_out;
                    col_cnt_d       = col_cnt_q + 2'd1;
                    if (col_cnt_q == 2'd3) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, counter and work register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            col_cnt_q <= 2'd0;
            // NOTE: the work register is reset too, so out_data reads 0 during reset.
            work_q    <= '0;
`ifdef INV_MIXCOL_FWD_EN
            mode_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            work_q    <= work_d;
`ifdef INV_MIXCOL_FWD_EN
            mode_q    <= mode_d;
`endif
        end
    end

endmodule
